writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, entries per source queue (power of two, >=2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost arbitrations before ALU is forced to win.
REQ-004 SHALL have ports i_clk in 1 clock; i_rstn in 1 reset, one clock, asynchronous active-low.
REQ-005 SHALL have ports i_Alu_valid in 1, i_Alu_num in 5, i_Alu_data in WORD_SIZE, o_Alu_ready out 1: ALU result push.
REQ-006 SHALL have ports i_Lsu_valid in 1, i_Lsu_num in 5, i_Lsu_data in WORD_SIZE, o_Lsu_ready out 1: load result push.
REQ-007 SHALL have ports i_Rsv_en in 1, i_Rsv_num in 5: destination reservation from issue.
REQ-008 SHALL have ports o_Wen out 1, o_Wnum out 5, o_Wd out WORD_SIZE: register-file write port.
REQ-009 SHALL have ports o_Busy out 32 (pending-write mask) and o_Err out 1 (sticky protocol error).

Function
REQ-010 Push on a source SHALL occur when valid and ready are both high at a rising i_clk edge.
REQ-011 o_Alu_ready/o_Lsu_ready SHALL equal "own queue not full", registered-state only; no push-through when full even if a pop happens the same cycle.
REQ-012 Each queue SHALL be FIFO order; entry = {num, data}; pointers wrap modulo FIFO_DEPTH.
REQ-013 Each cycle, if any queue non-empty, exactly one head SHALL be popped: LSU wins by default; ALU wins if LSU empty or starve counter == STARVE_LIMIT.
REQ-014 Starve counter SHALL increment when ALU non-empty and LSU wins, clear when ALU wins, hold otherwise; saturates at STARVE_LIMIT.
REQ-015 Popped entry SHALL drive o_Wen/o_Wnum/o_Wd from flops on the next cycle: push at edge N -> earliest o_Wen high cycle N+1 to N+2 (one queue stage + output register).
REQ-016 Popped entry with num==0 SHALL produce o_Wen=0 (o_Wnum/o_Wd hold) and no scoreboard change.
REQ-017 With no pop, o_Wen SHALL be 0 next cycle; o_Wnum/o_Wd hold.
REQ-018 Reservation with i_Rsv_num!=0 SHALL set o_Busy[i_Rsv_num] next cycle; x0 reservations ignored.
REQ-019 Pop of entry with num!=0 SHALL clear o_Busy[num] in the same edge that loads the output register.
REQ-020 Set and clear of the same bit in one cycle: set SHALL win.
REQ-021 o_Err SHALL set and stay set until reset on: reservation of an already-busy register without a same-cycle clear, or pop of num!=0 whose busy bit is 0.
REQ-022 o_Busy SHALL reflect only registered state (no combinational path from i_Rsv_*).

Reset
REQ-023 i_rstn low SHALL asynchronously empty both queues, clear starve counter, o_Busy=0, o_Err=0, o_Wen=0, o_Wnum=0, o_Wd=0.
REQ-024 Ready outputs SHALL be 1 during and after reset; assertion mid-operation discards all queued entries without any write.
REQ-025 Deassertion SHALL be usable synchronously; first push accepted on the first rising edge with i_rstn high.

Structure
REQ-026 Shared package SHALL hold WORD_SIZE, STARVE_LIMIT default, and source enum {SRC_NONE, SRC_ALU, SRC_LSU}.
REQ-027 Queue SHALL be one sub-module wb_fifo (parameterised width/depth, push/pop/full/empty), instantiated twice.
REQ-028 Arbiter, starve counter, scoreboard and output register SHALL live in the top.

Verification
REQ-029 Reserve x5; ALU push {5, 0xDEADBEEF} -> o_Wen=1, o_Wnum=5, o_Wd=0xDEADBEEF two cycles later; o_Busy[5] 1 then 0.
REQ-030 Same-cycle ALU {3,0x11} and LSU {4,0x22} -> write x4 then x3 in consecutive cycles.
REQ-031 LSU pushes every cycle, ALU holds one entry -> ALU written after exactly STARVE_LIMIT=4 LSU writes.
REQ-032 Fill ALU queue (2 pushes, no pop possible under LSU pressure) -> o_Alu_ready=0; third push not accepted; order preserved.
REQ-033 Push {0, 0x55} -> o_Wen stays 0, o_Busy unchanged, o_Err 0; reserve x7 twice -> o_Err=1 sticky.
REQ-034 Reset asserted with both queues holding entries -> no write occurs, o_Busy=0, ready=1 immediately.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: widths, starvation default and
// the pop-source encoding used by the arbiter mux.
package writeback_arbiter_pkg;

    localparam int WB_WORD_SIZE    = 32;
    localparam int WB_STARVE_LIMIT = 4;
    localparam int WB_NUM_W        = 5;
    localparam int WB_NUM_REGS     = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_e;

    // Register x0 never takes part in the scoreboard, so it maps to an empty mask.
    function automatic logic [WB_NUM_REGS-1:0] reg_onehot(input logic [WB_NUM_W-1:0] num);
        logic [WB_NUM_REGS-1:0] mask;
        mask = '0;
        if (num != '0) begin
            mask[num] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO holding {num, data} writeback entries for one source.
// Full/empty come from registered pointers only, so a full queue never accepts a push.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    assign o_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU results onto the single register-file write port, with an
// LSU-priority arbiter, ALU starvation guard and a pending-write scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = WB_WORD_SIZE,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_Alu_valid,
    input  logic [WB_NUM_W-1:0]    i_Alu_num,
    input  logic [WORD_SIZE-1:0]   i_Alu_data,
    output logic                   o_Alu_ready,
    input  logic                   i_Lsu_valid,
    input  logic [WB_NUM_W-1:0]    i_Lsu_num,
    input  logic [WORD_SIZE-1:0]   i_Lsu_data,
    output logic                   o_Lsu_ready,
    input  logic                   i_Rsv_en,
    input  logic [WB_NUM_W-1:0]    i_Rsv_num,
    output logic                   o_Wen,
    output logic [WB_NUM_W-1:0]    o_Wnum,
    output logic [WORD_SIZE-1:0]   o_Wd,
    output logic [WB_NUM_REGS-1:0] o_Busy,
    output logic                   o_Err
);

    localparam int ENTRY_W  = WB_NUM_W + WORD_SIZE;
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                   w_alu_full;
    logic                   w_alu_empty;
    logic                   w_lsu_full;
    logic                   w_lsu_empty;
    logic                   w_alu_push;
    logic                   w_lsu_push;
    logic                   w_alu_pop;
    logic                   w_lsu_pop;
    logic [ENTRY_W-1:0]     w_alu_head;
    logic [ENTRY_W-1:0]     w_lsu_head;
    wb_src_e                w_src;
    logic [WB_NUM_W-1:0]    w_pop_num;
    logic [WORD_SIZE-1:0]   w_pop_data;
    logic                   w_starved;
    logic                   w_wr_valid;
    logic [WB_NUM_REGS-1:0] w_set_mask;
    logic [WB_NUM_REGS-1:0] w_clr_mask;
    logic                   w_rsv_conflict;
    logic                   w_pop_unreserved;

    logic [STARVE_W-1:0]    r_starve;
    logic [WB_NUM_REGS-1:0] r_busy;
    logic                   r_err;
    logic                   r_wen;
    logic [WB_NUM_W-1:0]    r_wnum;
    logic [WORD_SIZE-1:0]   r_wd;

    assign o_Alu_ready = ~w_alu_full;
    assign o_Lsu_ready = ~w_lsu_full;
    assign w_alu_push  = i_Alu_valid & ~w_alu_full;
    assign w_lsu_push  = i_Lsu_valid & ~w_lsu_full;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_alu_push),
        .i_data  ({i_Alu_num, i_Alu_data}),
        .i_pop   (w_alu_pop),
        .o_data  (w_alu_head),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty)
    );

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsu_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_lsu_push),
        .i_data  ({i_Lsu_num, i_Lsu_data}),
        .i_pop   (w_lsu_pop),
        .o_data  (w_lsu_head),
        .o_full  (w_lsu_full),
        .o_empty (w_lsu_empty)
    );

    assign w_starved = (r_starve == STARVE_MAX);

    // LSU has priority; the ALU only gets through when LSU is idle or it has waited too long.
    always_comb begin
        w_src      = SRC_NONE;
        w_pop_num  = '0;
        w_pop_data = '0;
        if (!w_alu_empty && (w_lsu_empty || w_starved)) begin
            w_src = SRC_ALU;
        end else if (!w_lsu_empty) begin
            w_src = SRC_LSU;
        end
        case (w_src)
            SRC_ALU: {w_pop_num, w_pop_data} = w_alu_head;
            SRC_LSU: {w_pop_num, w_pop_data} = w_lsu_head;
            default: ;
        endcase
    end

    assign w_alu_pop  = (w_src == SRC_ALU);
    assign w_lsu_pop  = (w_src == SRC_LSU);
    assign w_wr_valid = (w_src != SRC_NONE) && (w_pop_num != '0);

    assign w_clr_mask = w_wr_valid ? reg_onehot(w_pop_num) : '0;
    assign w_set_mask = i_Rsv_en ? reg_onehot(i_Rsv_num) : '0;

    // A re-reservation is legal only if the same register retires in this very cycle.
    assign w_rsv_conflict   = |(w_set_mask & r_busy & ~w_clr_mask);
    assign w_pop_unreserved = |(w_clr_mask & ~r_busy);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_starve <= '0;
        end else if (w_alu_pop) begin
            r_starve <= '0;
        end else if (w_lsu_pop && !w_alu_empty && !w_starved) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (w_rsv_conflict || w_pop_unreserved) begin
                r_err <= 1'b1;
            end
        end
    end

    // x0 pops and idle cycles drop the strobe but keep the last address/data on the port.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wen  <= 1'b0;
            r_wnum <= '0;
            r_wd   <= '0;
        end else begin
            r_wen <= w_wr_valid;
            if (w_wr_valid) begin
                r_wnum <= w_pop_num;
                r_wd   <= w_pop_data;
            end
        end
    end

    assign o_Wen  = r_wen;
    assign o_Wnum = r_wnum;
    assign o_Wd   = r_wd;
    assign o_Busy = r_busy;
    assign o_Err  = r_err;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected writes are queued as stimulus
// is issued and a forked monitor retires them whenever o_Wen is seen.
module tb_writeback_arbiter;

    logic        i_clk;
    logic        i_rstn;
    logic        i_Alu_valid;
    logic [4:0]  i_Alu_num;
    logic [31:0] i_Alu_data;
    logic        o_Alu_ready;
    logic        i_Lsu_valid;
    logic [4:0]  i_Lsu_num;
    logic [31:0] i_Lsu_data;
    logic        o_Lsu_ready;
    logic        i_Rsv_en;
    logic [4:0]  i_Rsv_num;
    logic        o_Wen;
    logic [4:0]  o_Wnum;
    logic [31:0] o_Wd;
    logic [31:0] o_Busy;
    logic        o_Err;

    int n_cmp;
    int n_fail;
    logic [36:0] exp_q[$];

    writeback_arbiter #(
        .WORD_SIZE    (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_Alu_valid (i_Alu_valid),
        .i_Alu_num   (i_Alu_num),
        .i_Alu_data  (i_Alu_data),
        .o_Alu_ready (o_Alu_ready),
        .i_Lsu_valid (i_Lsu_valid),
        .i_Lsu_num   (i_Lsu_num),
        .i_Lsu_data  (i_Lsu_data),
        .o_Lsu_ready (o_Lsu_ready),
        .i_Rsv_en    (i_Rsv_en),
        .i_Rsv_num   (i_Rsv_num),
        .o_Wen       (o_Wen),
        .o_Wnum      (o_Wnum),
        .o_Wd        (o_Wd),
        .o_Busy      (o_Busy),
        .o_Err       (o_Err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_write(input logic [4:0] num, input logic [31:0] data);
        exp_q.push_back({num, data});
    endtask

    task automatic reserve(input logic [4:0] num);
        i_Rsv_en  = 1'b1;
        i_Rsv_num = num;
        step();
        i_Rsv_en  = 1'b0;
        i_Rsv_num = '0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] num, input logic [31:0] data);
        i_Alu_valid = v;
        i_Alu_num   = num;
        i_Alu_data  = data;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] num, input logic [31:0] data);
        i_Lsu_valid = v;
        i_Lsu_num   = num;
        i_Lsu_data  = data;
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge i_clk);
            if (o_Wen === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got x%0d=0x%08h, required no write", o_Wnum, o_Wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_Wnum, o_Wd} !== e) begin
                        n_fail++;
                        $display("FAIL write_order: got x%0d=0x%08h, required x%0d=0x%08h",
                                 o_Wnum, o_Wd, e[36:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        i_rstn = 1'b1;
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        i_Rsv_en  = 1'b0;
        i_Rsv_num = '0;
        fork
            monitor();
        join_none

        #2 i_rstn = 1'b0;
        #1;
        check("rst_alu_ready", o_Alu_ready, 1);
        check("rst_lsu_ready", o_Lsu_ready, 1);
        check("rst_busy", o_Busy, 0);
        check("rst_err", o_Err, 0);
        check("rst_wen", o_Wen, 0);
        check("rst_wnum", o_Wnum, 0);
        check("rst_wd", o_Wd, 0);
        idle(2);
        i_rstn = 1'b1;

        // Basic reserve / write / retire of x5
        reserve(5);
        check("busy5_set", o_Busy[5], 1);
        drive_alu(1'b1, 5, 32'hDEADBEEF);
        exp_write(5, 32'hDEADBEEF);
        step();
        drive_alu(1'b0, '0, '0);
        check("busy5_held", o_Busy[5], 1);
        check("wen_not_yet", o_Wen, 0);
        step();
        check("wen_x5", o_Wen, 1);
        check("wnum_x5", o_Wnum, 5);
        check("wd_x5", o_Wd, 32'hDEADBEEF);
        check("busy5_clr", o_Busy[5], 0);
        step();
        check("wen_drop", o_Wen, 0);
        check("wd_hold", o_Wd, 32'hDEADBEEF);

        // Simultaneous pushes: LSU first, then ALU
        reserve(3);
        reserve(4);
        drive_alu(1'b1, 3, 32'h11);
        drive_lsu(1'b1, 4, 32'h22);
        exp_write(4, 32'h22);
        exp_write(3, 32'h11);
        step();
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        idle(4);
        check("busy_after_pair", o_Busy, 0);
        check("err_after_pair", o_Err, 0);

        // Starvation: ALU entry waits exactly four LSU writes
        for (int r = 10; r <= 15; r++) reserve(5'(r));
        reserve(20);
        drive_alu(1'b1, 20, 32'hA0A0_0020);
        drive_lsu(1'b1, 10, 32'h1000_000A);
        exp_write(10, 32'h1000_000A);
        exp_write(11, 32'h1000_000B);
        exp_write(12, 32'h1000_000C);
        exp_write(13, 32'h1000_000D);
        exp_write(20, 32'hA0A0_0020);
        exp_write(14, 32'h1000_000E);
        exp_write(15, 32'h1000_000F);
        step();
        drive_alu(1'b0, '0, '0);
        for (int r = 11; r <= 15; r++) begin
            drive_lsu(1'b1, 5'(r), 32'h1000_0000 | 32'(r));
            step();
        end
        drive_lsu(1'b0, '0, '0);
        idle(5);
        check("busy_after_starve", o_Busy, 0);
        check("err_after_starve", o_Err, 0);

        // ALU queue fills under LSU pressure; x24 must never be accepted
        for (int r = 16; r <= 23; r++) reserve(5'(r));
        exp_write(16, 32'h16);
        exp_write(17, 32'h17);
        exp_write(18, 32'h18);
        exp_write(19, 32'h19);
        exp_write(22, 32'h22);
        exp_write(20, 32'h20);
        exp_write(21, 32'h21);
        exp_write(23, 32'h23);
        drive_lsu(1'b1, 16, 32'h16);
        drive_alu(1'b1, 22, 32'h22);
        step();
        drive_lsu(1'b1, 17, 32'h17);
        drive_alu(1'b1, 23, 32'h23);
        step();
        check("alu_full_f1", o_Alu_ready, 0);
        for (int r = 18; r <= 20; r++) begin
            drive_lsu(1'b1, 5'(r), 32'(r - 18 + 24));
            i_Lsu_data = (r == 18) ? 32'h18 : (r == 19) ? 32'h19 : 32'h20;
            drive_alu(1'b1, 24, 32'h24);
            step();
            check("alu_full_hold", o_Alu_ready, 0);
        end
        drive_lsu(1'b1, 21, 32'h21);
        drive_alu(1'b0, '0, '0);
        step();
        check("alu_ready_again", o_Alu_ready, 1);
        drive_lsu(1'b0, '0, '0);
        idle(5);
        check("busy_after_fill", o_Busy, 0);
        check("err_after_fill", o_Err, 0);

        // x0 result and double reservation
        drive_alu(1'b1, 0, 32'h55);
        step();
        drive_alu(1'b0, '0, '0);
        idle(3);
        check("x0_busy", o_Busy, 0);
        check("x0_err", o_Err, 0);
        reserve(7);
        check("rsv7_once_err", o_Err, 0);
        reserve(7);
        check("rsv7_twice_err", o_Err, 1);
        idle(3);
        check("err_sticky", o_Err, 1);
        check("busy7", o_Busy, 32'h0000_0080);

        // Reset with both queues occupied: entries are dropped without a write
        drive_alu(1'b1, 8, 32'h88);
        drive_lsu(1'b1, 9, 32'h99);
        step();
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        i_rstn = 1'b0;
        #1;
        check("mid_rst_alu_ready", o_Alu_ready, 1);
        check("mid_rst_lsu_ready", o_Lsu_ready, 1);
        check("mid_rst_busy", o_Busy, 0);
        check("mid_rst_err", o_Err, 0);
        check("mid_rst_wen", o_Wen, 0);
        idle(2);
        i_rstn = 1'b1;
        i_Rsv_en  = 1'b1;
        i_Rsv_num = 9;
        drive_lsu(1'b1, 9, 32'hCAFE_0009);
        exp_write(9, 32'hCAFE_0009);
        step();
        i_Rsv_en  = 1'b0;
        i_Rsv_num = '0;
        drive_lsu(1'b0, '0, '0);
        idle(4);
        check("post_rst_busy", o_Busy, 0);
        check("post_rst_err", o_Err, 0);
        check("pending_writes", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
